// File: rtl/hier_node_pkg.sv
// Shared types and helpers for the hierarchical counter node.
package hier_node_pkg;

    localparam int unsigned MAX_CHILDREN = 64;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StPresent
    } node_state_e;

    // Index width that never collapses to zero bits for a single child.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hier_leaf_counter.sv
// Saturating per-child event counter with a sticky saturation flag.
module hier_leaf_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             evt,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    localparam logic [CNT_W-1:0] CntMax = '1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            sat   <= 1'b0;
        end else if (clr) begin
            // An event in the clear cycle starts the next report.
            count <= CNT_W'(evt);
            sat   <= 1'b0;
        end else if (evt) begin
            if (count == CntMax) begin
                sat <= 1'b1;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/hier_node_array.sv
// Tree node: NUM_CHILDREN leaf counters drained round-robin into one valid/ready report stream.
// Optional out_parity port when HIER_NODE_PARITY_EN is defined.
module hier_node_array
    import hier_node_pkg::*;
#(
    parameter int unsigned NUM_CHILDREN = 10,
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned ID_W         = clog2_min1(NUM_CHILDREN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [NUM_CHILDREN-1:0] child_evt,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ID_W-1:0]         out_id,
    output logic [CNT_W-1:0]        out_count,
    output logic                    out_sat,
`ifdef HIER_NODE_PARITY_EN
    output logic                    out_parity,
`endif
    output logic                    busy
);

    localparam logic [ID_W-1:0] LastIdx = ID_W'(NUM_CHILDREN - 1);

    node_state_e             state_q;
    logic [ID_W-1:0]         ptr_q;
    logic [ID_W-1:0]         pass_q;
    logic [CNT_W-1:0]        cnt [NUM_CHILDREN];
    logic [NUM_CHILDREN-1:0] sat;
    logic [NUM_CHILDREN-1:0] clr;
    logic [CNT_W-1:0]        cur_cnt;
    logic                    cur_sat;
    logic                    hit;

    function automatic logic [ID_W-1:0] next_idx(input logic [ID_W-1:0] idx);
        return (idx == LastIdx) ? '0 : idx + 1'b1;
    endfunction

    always_comb begin
        cur_cnt = '0;
        cur_sat = 1'b0;
        for (int unsigned i = 0; i < NUM_CHILDREN; i++) begin
            if (ptr_q == ID_W'(i)) begin
                cur_cnt = cnt[i];
                cur_sat = sat[i];
            end
        end
    end

    assign hit  = (state_q == StScan) && en && (cur_cnt != '0);
    assign busy = (state_q != StIdle);

    for (genvar i = 0; i < NUM_CHILDREN; i++) begin : g_child
        assign clr[i] = hit && (ptr_q == ID_W'(i));

        hier_leaf_counter #(
            .CNT_W (CNT_W)
        ) u_leaf (
            .clk   (clk),
            .rst   (rst),
            .evt   (child_evt[i]),
            .clr   (clr[i]),
            .count (cnt[i]),
            .sat   (sat[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            pass_q     <= '0;
            out_valid  <= 1'b0;
            out_id     <= '0;
            out_count  <= '0;
            out_sat    <= 1'b0;
`ifdef HIER_NODE_PARITY_EN
            out_parity <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (en) begin
                        state_q <= StScan;
                        pass_q  <= '0;
                    end
                end
                StScan: begin
                    if (!en) begin
                        state_q <= StIdle;
                    end else if (hit) begin
                        state_q    <= StPresent;
                        out_valid  <= 1'b1;
                        out_id     <= ptr_q;
                        out_count  <= cur_cnt;
                        out_sat    <= cur_sat;
`ifdef HIER_NODE_PARITY_EN
                        out_parity <= ^{ptr_q, cur_cnt, cur_sat};
`endif
                    end else begin
                        // Pointer advances even on the last miss so a full pass lands back home.
                        ptr_q <= next_idx(ptr_q);
                        if (pass_q == LastIdx) begin
                            state_q <= StIdle;
                        end else begin
                            pass_q <= pass_q + 1'b1;
                        end
                    end
                end
                StPresent: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        ptr_q     <= next_idx(out_id);
                        pass_q    <= '0;
                        state_q   <= en ? StScan : StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_hier_node_array.sv
// Directed bench for hier_node_array: report-level model plus literal checks.
module tb_hier_node_array;

    localparam int N  = 10;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          out_ready = 1'b0;
    logic [N-1:0]  child_evt = '0;
    logic          out_valid;
    logic [3:0]    out_id;
    logic [CW-1:0] out_count;
    logic          out_sat;
    logic          busy;

    logic          en1 = 1'b0;
    logic          ready1 = 1'b0;
    logic [0:0]    evt1 = '0;
    logic          valid1;
    logic [0:0]    id1;
    logic [7:0]    cnt1;
    logic          sat1;
    logic          busy1;
`ifdef HIER_NODE_PARITY_EN
    logic          out_parity;
    logic          parity1;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    hier_node_array #(
        .NUM_CHILDREN (N),
        .CNT_W        (CW)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .child_evt  (child_evt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_id     (out_id),
        .out_count  (out_count),
        .out_sat    (out_sat),
`ifdef HIER_NODE_PARITY_EN
        .out_parity (out_parity),
`endif
        .busy       (busy)
    );

    hier_node_array #(
        .NUM_CHILDREN (1),
        .CNT_W        (8)
    ) u_dut1 (
        .clk        (clk),
        .rst        (rst),
        .en         (en1),
        .child_evt  (evt1),
        .out_valid  (valid1),
        .out_ready  (ready1),
        .out_id     (id1),
        .out_count  (cnt1),
        .out_sat    (sat1),
`ifdef HIER_NODE_PARITY_EN
        .out_parity (parity1),
`endif
        .busy       (busy1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, $signed(act), $signed(exp),
                     $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            cyc();
        end
        if (!seen) check({name, "_timeout"}, 64'd0, 64'd1);
    endtask

    // Report-level model: counts per child, sticky sat, round-robin start after last report.
    int           mcnt [N];
    bit           msat [N];
    int           mptr;
    int           m_exp;
    int           m_j;
    bit           m_rose;
    bit           vld_prev;
    bit           rdy_prev;
    logic [N-1:0] evt_prev;
    int           rep_id;
    int           rep_cnt;
    bit           rep_sat;

    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                mcnt[i] = 0;
                msat[i] = 1'b0;
            end
            mptr     = 0;
            vld_prev = 1'b0;
            rdy_prev = 1'b0;
            evt_prev = '0;
        end else begin
            m_rose = out_valid && !vld_prev;
            m_exp  = -1;
            if (vld_prev && !rdy_prev) begin
                check("hold_valid", out_valid, 1);
                check("hold_id", out_id, rep_id);
                check("hold_count", out_count, rep_cnt);
                check("hold_sat", out_sat, rep_sat);
            end
            if (m_rose) begin
                for (int k = 0; k < N; k++) begin
                    m_j = (mptr + k) % N;
                    if (m_exp < 0 && mcnt[m_j] != 0) m_exp = m_j;
                end
                check("rr_order", out_id, m_exp);
                if (m_exp >= 0) begin
                    check("snap_count", out_count, mcnt[m_exp]);
                    check("snap_sat", out_sat, msat[m_exp]);
`ifdef HIER_NODE_PARITY_EN
                    check("parity", out_parity,
                          ^{4'(m_exp), CW'(mcnt[m_exp]), msat[m_exp]});
`endif
                    rep_id  = m_exp;
                    rep_cnt = mcnt[m_exp];
                    rep_sat = msat[m_exp];
                    mptr    = (m_exp + 1) % N;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (m_rose && i == m_exp) begin
                    mcnt[i] = evt_prev[i] ? 1 : 0;
                    msat[i] = 1'b0;
                end else if (evt_prev[i]) begin
                    if (mcnt[i] == (1 << CW) - 1) msat[i] = 1'b1;
                    else mcnt[i] = mcnt[i] + 1;
                end
            end
            vld_prev = out_valid;
            rdy_prev = out_ready;
            evt_prev = child_evt;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        int  nbusy;
        int  sum;
        int  total;
        bit  any_valid;

        #1 rst = 1'b1;
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_id", out_id, 0);
        check("rst_count", out_count, 0);
        check("rst_sat", out_sat, 0);
        check("rst_busy", busy, 0);
        check("rst_valid_n1", valid1, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Latency: event on child 0 with idle node and pointer 0.
        out_ready = 1'b1;
        child_evt = 10'b1;
        cyc();
        child_evt = '0;
        en = 1'b1;
        check("lat_c1_valid", out_valid, 0);
        check("lat_c1_busy", busy, 0);
        cyc();
        check("lat_c2_valid", out_valid, 0);
        check("lat_c2_busy", busy, 1);
        cyc();
        check("lat_c3_valid", out_valid, 1);
        check("lat_id", out_id, 0);
        check("lat_count", out_count, 1);
        out_ready = 1'b0;
        en = 1'b0;
        cyc();
        check("en_drop_keeps_valid", out_valid, 1);
        out_ready = 1'b1;
        cyc();
        check("hs_valid_low", out_valid, 0);
        check("hs_idle", busy, 0);

        // Three pulses on child 4, then one empty pass.
        child_evt = 10'b1 << 4;
        repeat (3) cyc();
        child_evt = '0;
        en = 1'b1;
        wait_valid("c4");
        check("c4_id", out_id, 4);
        check("c4_count", out_count, 3);
        check("c4_sat", out_sat, 0);
        cyc();
        nbusy = 0;
        while (busy && nbusy < 30) begin
            nbusy++;
            cyc();
        end
        check("empty_pass_len", nbusy, 10);
        en = 1'b0;

        // Pointer at 5: child 7 before child 2.
        child_evt = (10'b1 << 2) | (10'b1 << 7);
        cyc();
        child_evt = '0;
        en = 1'b1;
        wait_valid("c7");
        check("wrap_first_id", out_id, 7);
        check("wrap_first_count", out_count, 1);
        cyc();
        out_ready = 1'b0;
        wait_valid("c2");
        check("wrap_second_id", out_id, 2);
        en = 1'b0;
        out_ready = 1'b1;
        cyc();

        // Event on child 3 in its clear cycle.
        child_evt = 10'b1 << 3;
        repeat (3) cyc();
        en = 1'b1;
        cyc();
        cyc();
        child_evt = '0;
        out_ready = 1'b0;
        check("clr_evt_valid", out_valid, 1);
        check("clr_evt_id", out_id, 3);
        check("clr_evt_count", out_count, 4);
        out_ready = 1'b1;
        cyc();
        wait_valid("c3b");
        check("clr_evt_second_id", out_id, 3);
        check("clr_evt_second_count", out_count, 1);
        en = 1'b0;
        cyc();

        // Saturation under backpressure, then child 5 accumulating during PRESENT.
        child_evt = 10'b1;
        repeat (20) cyc();
        child_evt = '0;
        en = 1'b1;
        out_ready = 1'b0;
        wait_valid("sat");
        check("sat_id", out_id, 0);
        check("sat_count", out_count, 15);
        check("sat_flag", out_sat, 1);
        child_evt = 10'b1 << 5;
        repeat (3) cyc();
        child_evt = '0;
        out_ready = 1'b1;
        cyc();
        wait_valid("c5");
        check("bp_id", out_id, 5);
        check("bp_count", out_count, 3);
        child_evt = 10'b1;
        cyc();
        child_evt = '0;
        wait_valid("c0b");
        check("after_sat_id", out_id, 0);
        check("after_sat_count", out_count, 1);
        check("after_sat_flag", out_sat, 0);
        en = 1'b0;
        cyc();

        // Asynchronous reset while a report is pending.
        child_evt = 10'b1 << 1;
        en = 1'b1;
        out_ready = 1'b0;
        cyc();
        child_evt = '0;
        wait_valid("pre_rst");
        check("pre_rst_valid", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_count", out_count, 0);
        check("async_rst_id", out_id, 0);
        check("async_rst_sat", out_sat, 0);
        check("async_rst_busy", busy, 0);
        cyc();
        cyc();
        rst = 1'b0;
        out_ready = 1'b1;
        any_valid = 1'b0;
        repeat (15) begin
            any_valid |= out_valid;
            cyc();
        end
        check("rst_discards_report", any_valid, 0);
        en = 1'b0;

        // Single-child node with toggling backpressure.
        sum = 0;
        total = 0;
        en1 = 1'b1;
        for (int i = 0; i < 80; i++) begin
            evt1   = (i < 60 && (i % 3) != 2) ? 1'b1 : 1'b0;
            ready1 = (i >= 60) || ((i % 4) < 2);
            total += int'(evt1);
            if (valid1) begin
                check("n1_id", id1, 0);
                if (ready1) sum += int'(cnt1);
            end
            cyc();
        end
        check("n1_total_pulses", total, 40);
        check("n1_sum", sum, total);
        check("n1_drained", valid1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hier_node_array.md
Name: hier_node_array

Overview:
- Parametrised successor to the fixed 10-child generated hierarchy node: instantiates NUM_CHILDREN leaf counter channels through a generate loop instead of hand-listed instances.
- Aggregates per-child event counts into a single valid/ready report stream using a round-robin scanner.
- Used as a reusable tree node: one instance per hierarchy level, and a node's report stream can feed a parent node.

Parameters:
- NUM_CHILDREN, 10, number of child channels; range 1..64.
- CNT_W, 8, width of each child event counter.
- ID_W, $clog2(NUM_CHILDREN) with a minimum of 1, width of the child index.

Ports:
- clk  in  1  single clock.
- rst  in  1  reset, asynchronous, active-high; clears all state.
- en  in  1  scanner enable; children keep counting when en=0.
- child_evt  in  NUM_CHILDREN  per-child event pulse, one count per cycle high.
- out_valid  out  1  a report is presented.
- out_ready  in  1  downstream accepts the report.
- out_id  out  ID_W  index of the reporting child.
- out_count  out  CNT_W  snapshot of that child's count.
- out_sat  out  1  the child counter saturated since its last report.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset: out_valid=0, out_id=0, out_count=0, out_sat=0, busy=0, all child counts=0, scan pointer=0, FSM=IDLE.
- Child leaf (per channel):
  - Count increments on child_evt and saturates at 2^CNT_W-1; the sticky sat flag sets on any attempted increment at max.
  - On clear: count becomes (child_evt ? 1 : 0) and sat clears. An event in the clear cycle is not lost.
- FSM states: IDLE, SCAN, PRESENT.
  - IDLE -> SCAN when en=1.
  - SCAN examines one child per cycle at the pointer:
    - count!=0: snapshot count/sat/id into output regs, assert clear to that child in the same cycle, go to PRESENT.
    - count==0: pointer advances.
    - After a full pass of NUM_CHILDREN cycles with no hit, return to IDLE.
    - en=0 in SCAN -> IDLE.
  - PRESENT: out_valid=1; outputs stable until out_valid&&out_ready. On the handshake cycle, pointer = hit index + 1 (wrap to 0 past NUM_CHILDREN-1), then go to SCAN if en=1, else IDLE. en falling in PRESENT does not drop out_valid.
- Latency: an event on child k with an idle node and pointer=k yields out_valid 3 cycles later:
  - cycle 1: count registered;
  - cycle 2: IDLE->SCAN;
  - cycle 3: SCAN hit, PRESENT registered.
- Fairness: strict round-robin from the entry after the last reported child. No child is reported twice while another nonzero child waits.
- Pointer wrap: NUM_CHILDREN-1 -> 0. For non-power-of-2 counts, pointer values >= NUM_CHILDREN never occur.
- Simultaneous events:
  - An event on the child being cleared counts toward the next report.
  - Events on other children during PRESENT accumulate normally.
- Backpressure: counts keep accumulating during PRESENT, saturating with sat set.
- Reset mid-operation: any state returns to reset values immediately. A pending report is discarded.
- NUM_CHILDREN=1: ID_W=1, out_id always 0.

Optional Feature:
- Macro HIER_NODE_PARITY_EN.
- Defined: extra output out_parity (1 bit) = even parity over {out_id, out_count, out_sat}, registered with the snapshot and valid whenever out_valid=1.
- Undefined: port absent, no parity logic.

Decomposition:
- Package hier_node_pkg: FSM state enum (IDLE/SCAN/PRESENT), MAX_CHILDREN=64 constant, and a clog2-with-minimum-1 helper function.
- Sub-module hier_leaf_counter, parameter CNT_W, ports clk, rst, evt, clr, count, sat; one instance per child.
- Top holds the FSM, the pointer, the snapshot registers and the generate loop.

Test Plan:
1. Reset mid-PRESENT: rst pulse asynchronously -> out_valid=0, out_count=0, busy=0 immediately, before the next clk edge.
2. NUM_CHILDREN=10, en=1, out_ready=1, 3 pulses on child 4 -> one report, out_id=4, out_count=3, out_sat=0; then the node returns to IDLE after a 10-cycle empty pass.
3. Children 2 and 7 each pulsed once, pointer at 5 -> child 7 reported first, then child 2 (wrap through 9->0).
4. CNT_W=4, out_ready=0, 20 pulses on child 0 -> out_count=15, out_sat=1; after the handshake the child count is 0 and sat is cleared.
5. Event on child 3 in the same cycle its clear is issued -> first report out_count=N, a second report follows with out_count=1.
6. NUM_CHILDREN=1, continuous events with out_ready toggling -> out_id=0 always, and the sum of reported counts equals the total pulses.
